// File: rtl/router_pkg.sv
// Shared constants and state encoding for the router ingress control FSM.
package router_pkg;

  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned NUM_DEST   = 3;

  // Header address value that selects no FIFO.
  localparam logic [ADDR_WIDTH-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    StDecodeAddress    = 3'd0,
    StLoadFirstData    = 3'd1,
    StLoadData         = 3'd2,
    StFifoFullState    = 3'd3,
    StLoadAfterFull    = 3'd4,
    StLoadParity       = 3'd5,
    StCheckParityError = 3'd6,
    StWaitTillEmpty    = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Ingress control FSM for the 1x3 router.
// Decodes the header destination address, sequences writes into the selected
// output FIFO, stalls while that FIFO is full and triggers the parity check at
// the end of each packet.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   pkt_valid               source is driving packet bytes
//   data_in[1:0]            header address bits, sampled in DECODE_ADDRESS
//   fifo_full               full flag of the selected FIFO
//   fifo_empty_0/1/2        per-FIFO empty flags
//   soft_reset_0/1/2        per-FIFO read-side timeout resets
//   parity_done             parity byte captured by the register block
//   low_pkt_valid           pkt_valid fell while stalled on a full FIFO
//   dest_addr[1:0]          latched destination address
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                           one-hot state indications
//   write_enb_reg           write enable to the selected FIFO
//   busy                    source must hold its current byte
module router_fsm
  import router_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty_0,
  input  logic                  fifo_empty_1,
  input  logic                  fifo_empty_2,
  input  logic                  soft_reset_0,
  input  logic                  soft_reset_1,
  input  logic                  soft_reset_2,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic [ADDR_WIDTH-1:0] dest_addr,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  busy
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;

  // Padded to four entries so the invalid address indexes a constant 0.
  logic [3:0] empty_vec;
  logic [3:0] soft_vec;

  assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StDecodeAddress;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;

    unique case (state_q)
      StDecodeAddress: begin
        if (pkt_valid && (data_in != INVALID_ADDR)) begin
          dest_d  = data_in;
          state_d = empty_vec[data_in] ? StLoadFirstData : StWaitTillEmpty;
        end
      end
      StLoadFirstData: state_d = StLoadData;
      StLoadData: begin
        if (fifo_full)       state_d = StFifoFullState;
        else if (!pkt_valid) state_d = StLoadParity;
      end
      StFifoFullState: begin
        if (!fifo_full) state_d = StLoadAfterFull;
      end
      StLoadAfterFull: begin
        if (parity_done)        state_d = StDecodeAddress;
        else if (low_pkt_valid) state_d = StLoadParity;
        else                    state_d = StLoadData;
      end
      StLoadParity: state_d = StCheckParityError;
      StCheckParityError: begin
        state_d = fifo_full ? StFifoFullState : StDecodeAddress;
      end
      StWaitTillEmpty: begin
        if (empty_vec[dest_q]) state_d = StLoadFirstData;
      end
      default: state_d = StDecodeAddress;
    endcase

    // Timeout on the selected FIFO abandons the packet; dest_addr is kept.
    if (soft_vec[dest_q]) state_d = StDecodeAddress;
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;

    unique case (state_q)
      StDecodeAddress: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      StLoadFirstData: lfd_state = 1'b1;
      StLoadData: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      StFifoFullState: full_state = 1'b1;
      StLoadAfterFull: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      StLoadParity:       write_enb_reg = 1'b1;
      StCheckParityError: rst_int_reg   = 1'b1;
      StWaitTillEmpty:    ;
      default:            ;
    endcase
  end

  assign dest_addr = dest_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with a scoreboard of expected output vectors.
module tb_router_fsm;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [1:0] dest_addr;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  router_fsm dut (
    .clk          (clk),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty_0 (fifo_empty_0),
    .fifo_empty_1 (fifo_empty_1),
    .fifo_empty_2 (fifo_empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .dest_addr    (dest_addr),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {D, LFD, LD, FF, LAF, LP, CP, WTE} st_e;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;

  // {detect, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] outs_of(st_e s);
    case (s)
      D:       return 8'b1000_0000;
      LFD:     return 8'b0100_0001;
      LD:      return 8'b0010_0010;
      FF:      return 8'b0000_1001;
      LAF:     return 8'b0001_0011;
      LP:      return 8'b0000_0011;
      CP:      return 8'b0000_0101;
      default: return 8'b0000_0001;
    endcase
  endfunction

  task automatic push(input string tag, input st_e s, input logic [1:0] dest);
    exp_q.push_back({outs_of(s), dest});
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    string      tag;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
             write_enb_reg, busy, dest_addr};
    n_checks++;
    assert (obs_v === exp_v)
    else begin
      n_fails++;
      $error("FAIL %s: observed %b required %b", tag, obs_v, exp_v);
    end
  endtask

  // Expectation for the state after the coming clock edge.
  task automatic cyc(input string tag, input st_e s, input logic [1:0] dest);
    push(tag, s, dest);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input string tag, input st_e s, input logic [1:0] dest);
    push(tag, s, dest);
    compare();
  endtask

  initial begin
    resetn        = 1'b0;
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
    #2;
    check_now("reset", D, 2'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc("idle", D, 2'd0);

    // Basic packet to FIFO 1: header, 3 payload bytes, parity.
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("p1_hdr", LFD, 2'd1);
    data_in = 2'd0;
    cyc("p1_ld0", LD, 2'd1);
    cyc("p1_ld1", LD, 2'd1);
    cyc("p1_ld2", LD, 2'd1);
    pkt_valid = 1'b0;
    cyc("p1_par", LP, 2'd1);
    cyc("p1_chk", CP, 2'd1);
    cyc("p1_done", D, 2'd1);

    // FIFO 2 not empty: wait five cycles, then load.
    fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
    cyc("p2_wait0", WTE, 2'd2);
    data_in = 2'd0;
    for (int i = 1; i < 5; i++) cyc("p2_wait", WTE, 2'd2);
    fifo_empty_2 = 1'b1;
    cyc("p2_lfd", LFD, 2'd2);
    pkt_valid = 1'b0;
    cyc("p2_ld", LD, 2'd2);
    cyc("p2_par", LP, 2'd2);
    cyc("p2_chk", CP, 2'd2);
    cyc("p2_done", D, 2'd2);

    // FIFO 0 full for three cycles during payload.
    pkt_valid = 1'b1; data_in = 2'd0;
    cyc("p3_lfd", LFD, 2'd0);
    cyc("p3_ld", LD, 2'd0);
    fifo_full = 1'b1;
    cyc("p3_full0", FF, 2'd0);
    cyc("p3_full1", FF, 2'd0);
    cyc("p3_full2", FF, 2'd0);
    fifo_full = 1'b0;
    cyc("p3_laf", LAF, 2'd0);
    cyc("p3_ld_again", LD, 2'd0);
    pkt_valid = 1'b0;
    cyc("p3_par", LP, 2'd0);
    fifo_full = 1'b1;
    cyc("p3_chk", CP, 2'd0);
    cyc("p3_chk_full", FF, 2'd0);
    fifo_full = 1'b0;
    parity_done = 1'b1;
    cyc("p3_laf_pd", LAF, 2'd0);
    cyc("p3_done", D, 2'd0);
    parity_done = 1'b0;

    // Full on last payload: low_pkt_valid path, then parity_done path.
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("p4_lfd", LFD, 2'd1);
    cyc("p4_ld", LD, 2'd1);
    fifo_full = 1'b1; pkt_valid = 1'b0;
    cyc("p4_full", FF, 2'd1);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    cyc("p4_laf", LAF, 2'd1);
    cyc("p4_par", LP, 2'd1);
    low_pkt_valid = 1'b0;
    cyc("p4_chk", CP, 2'd1);
    cyc("p4_done", D, 2'd1);
    pkt_valid = 1'b1; data_in = 2'd1;
    cyc("p5_lfd", LFD, 2'd1);
    cyc("p5_ld", LD, 2'd1);
    fifo_full = 1'b1; pkt_valid = 1'b0;
    cyc("p5_full", FF, 2'd1);
    fifo_full = 1'b0; parity_done = 1'b1; low_pkt_valid = 1'b1;
    cyc("p5_laf", LAF, 2'd1);
    cyc("p5_pd_done", D, 2'd1);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Invalid address is ignored and dest_addr holds.
    pkt_valid = 1'b1; data_in = 2'b11;
    cyc("inv0", D, 2'd1);
    cyc("inv1", D, 2'd1);

    // Soft reset of the selected FIFO aborts the packet.
    data_in = 2'd0;
    cyc("sr_lfd", LFD, 2'd0);
    cyc("sr_ld", LD, 2'd0);
    soft_reset_0 = 1'b1;
    cyc("sr_sel", D, 2'd0);
    soft_reset_0 = 1'b0;

    // Soft reset of a non-selected FIFO is ignored.
    data_in = 2'd1;
    cyc("srn_lfd", LFD, 2'd1);
    cyc("srn_ld", LD, 2'd1);
    soft_reset_0 = 1'b1;
    cyc("srn_ignored", LD, 2'd1);
    soft_reset_0 = 1'b0;
    cyc("srn_ld2", LD, 2'd1);

    // Asynchronous reset mid-packet.
    resetn = 1'b0;
    #1;
    check_now("async_rst", D, 2'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1; pkt_valid = 1'b0;
    cyc("post_rst", D, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Control FSM for the 1x3 router ingress path. It decodes the 2-bit destination address from the header byte and sequences writes into one of the three output FIFOs. It drives the per-byte write-enable and the header (lfd_state) and load phases, stalls on FIFO full, and triggers the parity check at end of packet. It sits between the input register/parity block and the three router FIFOs.

Parameters:
ADDR_WIDTH, 2, width of destination address field (header bits [1:0]).
NUM_DEST, 3, number of output FIFOs; address NUM_DEST (2'b11) is invalid.

Ports:
clk  input  1  system clock, all state changes on posedge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source is driving packet bytes; deasserts with the parity byte
data_in  input  2  header address bits (data bus [1:0]), sampled in DECODE_ADDRESS
fifo_full  input  1  full flag of the currently selected FIFO (muxed externally)
fifo_empty_0/1/2  input  1 each  empty flags of FIFO 0/1/2
soft_reset_0/1/2  input  1 each  soft reset of FIFO 0/1/2 (read-side timeout)
parity_done  input  1  parity byte has been captured by the register block
low_pkt_valid  input  1  pkt_valid fell while the FSM was stalled in FIFO_FULL_STATE
dest_addr  output  2  latched destination address; selects write FIFO and full mux
detect_add  output  1  FSM in DECODE_ADDRESS
lfd_state  output  1  FSM in LOAD_FIRST_DATA (header write cycle)
ld_state  output  1  FSM in LOAD_DATA
laf_state  output  1  FSM in LOAD_AFTER_FULL
full_state  output  1  FSM in FIFO_FULL_STATE
write_enb_reg  output  1  write enable to the selected FIFO
rst_int_reg  output  1  FSM in CHECK_PARITY_ERROR; clears internal parity error logic
busy  output  1  source must hold its current byte

Behaviour:
- States (3-bit encoding): DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Reset (resetn low, async): state=DECODE_ADDRESS, dest_addr=0. Hence detect_add=1 and all other outputs 0.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid & data_in==k (k<3) & fifo_empty_k -> LOAD_FIRST_DATA.
    - pkt_valid & data_in==k & !fifo_empty_k -> WAIT_TILL_EMPTY.
    - data_in==3 or !pkt_valid -> stay.
    - dest_addr<=data_in whenever pkt_valid & data_in!=3 in this state.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: fifo_full -> stay, else LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA, else stay.
- Soft reset: soft_reset_k high with dest_addr==k forces next state DECODE_ADDRESS from any state. This overrides all transitions above. Soft reset of a non-selected FIFO has no effect.
- Outputs are Moore, decoded from current state only, with no added latency:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = all states except DECODE_ADDRESS and LOAD_DATA.
  - Exactly one of detect_add/lfd_state/ld_state/laf_state/full_state/rst_int_reg is high, or none in LOAD_PARITY/WAIT_TILL_EMPTY.
- lfd_state is high exactly one cycle per accepted packet.
- dest_addr holds from decode until the next accepted header. It is not cleared by soft reset.
- Async reset mid-packet returns to DECODE_ADDRESS immediately. The partial packet is abandoned.

Decomposition:
- Package router_pkg holds the state encoding enum/localparams, ADDR_WIDTH, NUM_DEST and INVALID_ADDR=2'b11.
- No sub-module: one sequential state register, a dest_addr register and next-state/output decode.

Test Plan:
- Header 8'h0D (len 3, addr 1), fifo_empty_1=1, pkt_valid 4 cycles: dest_addr=1, lfd 1 cycle; ld 3 cycles, LOAD_PARITY, CHECK_PARITY (rst_int_reg 1 cycle), back to DECODE; write_enb 4 cycles.
- Header addr 2 with fifo_empty_2=0 for 5 cycles: WAIT_TILL_EMPTY and busy=1 for 5 cycles; on empty, LOAD_FIRST_DATA next cycle.
- fifo_full=1 for 3 cycles in LOAD_DATA: full_state 3 cycles, busy=1, write_enb=0; then LOAD_AFTER_FULL 1 cycle, write_enb=1, back to LOAD_DATA.
- Full during last payload with low_pkt_valid=1, parity_done=0: FIFO_FULL -> LOAF_AFTER_FULL -> LOAD_PARITY; with parity_done=1: LOAD_AFTER_FULL -> DECODE_ADDRESS.
- data_in=2'b11 with pkt_valid: FSM stays in DECODE_ADDRESS, dest_addr unchanged, write_enb=0.
- soft_reset_0 pulse in LOAD_DATA with dest_addr=0: DECODE next cycle. The same pulse with dest_addr=1 has no effect. resetn low mid-packet: immediate detect_add=1.
